// File: rtl/frac_line_feeder_pkg.sv
// Shared definitions for the fractional-search pixel interface: state encoding,
// default geometry (also used by the search engine) and the per-block beat count.
package frac_line_feeder_pkg;

    localparam int FLF_TAPS   = 8;
    localparam int FLF_BLK_H  = 8;
    localparam int FLF_FILT_W = 128;
    localparam int FLF_REF_W  = 64;
    localparam int FLF_AW     = 10;
    localparam int FLF_BEATS  = FLF_TAPS + FLF_BLK_H - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        STREAM  = 2'd2,
        DRAIN   = 2'd3
    } state_t;

endpackage

// File: rtl/frac_feed_fifo.sv
// Two-entry synchronous FIFO that absorbs the one-cycle line-memory latency.
// Async active-low reset; i_clr flushes all entries.
module frac_feed_fifo
    import frac_line_feeder_pkg::*;
#(
    parameter int W = FLF_FILT_W + FLF_REF_W + 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    // Producer never pushes into a full FIFO and consumer never pops an empty one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_clr) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/frac_line_feeder.sv
// Streams TAPS-1 filter-only prefill beats then BLK_H filter+reference beats per block.
// Optional FRAC_FEED_ABORT_EN adds an abort input that drops the block and returns to IDLE.
// Handshake: a beat transfers on a rising edge where out_valid && out_ready; while
// out_valid is high and out_ready low, the beat and out_valid are held unchanged.
module frac_line_feeder
    import frac_line_feeder_pkg::*;
#(
    parameter int TAPS   = FLF_TAPS,
    parameter int BLK_H  = FLF_BLK_H,
    parameter int FILT_W = FLF_FILT_W,
    parameter int REF_W  = FLF_REF_W,
    parameter int AW     = FLF_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef FRAC_FEED_ABORT_EN
    input  logic              abort,
`endif
    input  logic [AW-1:0]     filt_base,
    input  logic [AW-1:0]     ref_base,
    output logic              busy,
    output logic              done,
    output logic              filt_rd,
    output logic [AW-1:0]     filt_addr,
    input  logic [FILT_W-1:0] filt_data,
    output logic              ref_rd,
    output logic [AW-1:0]     ref_addr,
    input  logic [REF_W-1:0]  ref_data,
    output logic [FILT_W-1:0] filter_pix,
    output logic [REF_W-1:0]  ref_pix,
    output logic              out_valid,
    output logic              ref_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [1:0]        dbg_state
);

    localparam int CW    = $clog2(TAPS + BLK_H);
    localparam int BEATS = TAPS + BLK_H - 1;
    localparam int EW    = FILT_W + REF_W + 2;
    localparam logic [AW-1:0] PRE_OFS = AW'(TAPS - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_filt_base;
    logic [AW-1:0] r_ref_base;
    logic [CW-1:0] r_cnt;
    logic          r_infl;
    logic          r_infl_ref;
    logic          r_infl_last;
    logic          w_abort;
    logic          w_start_ok;
    logic          w_issue;
    logic          w_room;
    logic          w_pop;
    logic          w_push;
    logic          w_done;
    logic [1:0]    w_count;
    logic [EW-1:0] w_head;
    logic [EW-1:0] w_push_data;

`ifdef FRAC_FEED_ABORT_EN
    assign w_abort    = abort && (r_state != IDLE);
    assign w_start_ok = start && !abort;
`else
    assign w_abort    = 1'b0;
    assign w_start_ok = start;
`endif

    // A slot freed by this cycle's pop may be claimed by this cycle's read.
    assign out_valid = (w_count != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign w_room    = ({1'b0, w_count} + {2'b00, r_infl}) < (3'd2 + {2'b00, w_pop});
    assign w_issue   = ((r_state == PREFILL) || (r_state == STREAM)) && w_room && !w_abort;

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            IDLE:    if (w_start_ok) w_next = PREFILL;
            PREFILL: if (w_issue && (r_cnt == CW'(TAPS - 2))) w_next = STREAM;
            STREAM:  if (w_issue && (r_cnt == CW'(BEATS - 1))) w_next = DRAIN;
            DRAIN: begin
                if ((w_count == 2'd0) && !r_infl) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (w_abort) begin
            w_next = IDLE;
            w_done = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_filt_base <= '0;
            r_ref_base  <= '0;
            r_cnt       <= '0;
            r_infl      <= 1'b0;
            r_infl_ref  <= 1'b0;
            r_infl_last <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && w_start_ok) begin
                r_filt_base <= filt_base;
                r_ref_base  <= ref_base;
                r_cnt       <= '0;
            end else if (w_issue) begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_infl      <= w_issue;
            r_infl_ref  <= (r_state == STREAM);
            r_infl_last <= (r_cnt == CW'(BEATS - 1));
        end
    end

    // Data returning for an aborted block is dropped rather than queued.
    assign w_push      = r_infl && !w_abort;
    assign w_push_data = {filt_data, (r_infl_ref ? ref_data : {REF_W{1'b0}}), r_infl_ref, r_infl_last};

    frac_feed_fifo #(.W(EW)) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .i_clr       (w_abort),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign filter_pix = out_valid ? w_head[EW-1 -: FILT_W] : '0;
    assign ref_pix    = out_valid ? w_head[REF_W+1 -: REF_W] : '0;
    assign ref_valid  = out_valid && w_head[1];
    assign out_last   = out_valid && w_head[0];

    assign filt_rd   = w_issue;
    assign filt_addr = w_issue ? (r_filt_base + AW'(r_cnt)) : '0;
    assign ref_rd    = w_issue && (r_state == STREAM);
    assign ref_addr  = ref_rd ? (r_ref_base + AW'(r_cnt) - PRE_OFS) : '0;

    assign busy      = (r_state != IDLE);
    assign done      = w_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_frac_line_feeder.sv
// Self-checking bench for frac_line_feeder: line memories, scoreboard and
// address/stability monitors; abort scenario is built when FRAC_FEED_ABORT_EN is defined.
module tb_frac_line_feeder;
  import frac_line_feeder_pkg::*;

  localparam int TAPS   = FLF_TAPS;
  localparam int FILT_W = FLF_FILT_W;
  localparam int REF_W  = FLF_REF_W;
  localparam int AW     = FLF_AW;
  localparam int BEATS  = FLF_BEATS;
  localparam int BW     = FILT_W + REF_W + 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              start;
  logic              abort;
  logic [AW-1:0]     filt_base, ref_base;
  logic              busy, done, filt_rd, ref_rd;
  logic [AW-1:0]     filt_addr, ref_addr;
  logic [FILT_W-1:0] filt_data;
  logic [REF_W-1:0]  ref_data;
  logic [FILT_W-1:0] filter_pix;
  logic [REF_W-1:0]  ref_pix;
  logic              out_valid, ref_valid, out_last, out_ready;
  logic [1:0]        dbg_state;

  frac_line_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef FRAC_FEED_ABORT_EN
    .abort      (abort),
`endif
    .filt_base  (filt_base),
    .ref_base   (ref_base),
    .busy       (busy),
    .done       (done),
    .filt_rd    (filt_rd),
    .filt_addr  (filt_addr),
    .filt_data  (filt_data),
    .ref_rd     (ref_rd),
    .ref_addr   (ref_addr),
    .ref_data   (ref_data),
    .filter_pix (filter_pix),
    .ref_pix    (ref_pix),
    .out_valid  (out_valid),
    .ref_valid  (ref_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .dbg_state  (dbg_state)
  );

  // synchronous line memories
  logic [FILT_W-1:0] filt_mem [1 << AW];
  logic [REF_W-1:0]  ref_mem  [1 << AW];

  always @(posedge clk) begin
    if (filt_rd) filt_data <= filt_mem[filt_addr];
    if (ref_rd)  ref_data  <= ref_mem[ref_addr];
  end

  // scoreboard state
  logic [BW-1:0] exp_q[$];
  logic [AW-1:0] exp_fa_q[$];
  logic [AW-1:0] exp_ra_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int exp_done = 0;
  int n_iss    = 0;
  int n_acc    = 0;
  int cyc      = 0;
  int last_acc_cyc = -10;
  logic rnd_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the block as a list of beats derived from line indices.
  task automatic start_block(input logic [AW-1:0] fb, input logic [AW-1:0] rb, input bit expect_done);
    logic [AW-1:0] fa, ra;
    logic [REF_W-1:0] rl;
    for (int b = 0; b < BEATS; b++) begin
      fa = fb + AW'(b);
      exp_fa_q.push_back(fa);
      if (b >= TAPS - 1) begin
        ra = rb + AW'(b - (TAPS - 1));
        exp_ra_q.push_back(ra);
        rl = ref_mem[ra];
      end else begin
        rl = '0;
      end
      exp_q.push_back({filt_mem[fa], rl, (b >= TAPS - 1), (b == BEATS - 1)});
    end
    if (expect_done) exp_done++;
    n_iss = 0;
    n_acc = 0;
    @(posedge clk); #1;
    start = 1'b1;
    filt_base = fb;
    ref_base = rb;
    @(posedge clk); #1;
    start = 1'b0;
    filt_base = $urandom_range(0, (1 << AW) - 1);
    ref_base = $urandom_range(0, (1 << AW) - 1);
  endtask

  task automatic wait_done(input int budget);
    int d0 = n_done;
    int t = 0;
    while (n_done == d0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    check("done_seen", (n_done != d0), 1'b1);
  endtask

  task automatic flush_sb();
    exp_q.delete();
    exp_fa_q.delete();
    exp_ra_q.delete();
  endtask

  // ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: addresses, beats, stability, outstanding reads, done timing
  logic          prev_v = 1'b0;
  logic          prev_r = 1'b0;
  logic [BW-1:0] prev_beat = '0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", {filter_pix, ref_pix, ref_valid, out_last}, prev_beat);
      end
      if (filt_rd) begin
        if (exp_fa_q.size() == 0) check("filt_rd_extra", 1'b1, 1'b0);
        else check("filt_addr", filt_addr, exp_fa_q.pop_front());
        n_iss++;
      end
      if (ref_rd) begin
        check("ref_rd_not_prefill", (n_iss > TAPS - 1), 1'b1);
        if (exp_ra_q.size() == 0) check("ref_rd_extra", 1'b1, 1'b0);
        else check("ref_addr", ref_addr, exp_ra_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("beat_extra", 1'b1, 1'b0);
        else check("beat", {filter_pix, ref_pix, ref_valid, out_last}, exp_q.pop_front());
        n_acc++;
        last_acc_cyc = cyc;
      end
      if (filt_rd) check("outstanding_le2", ((n_iss - n_acc) <= 2), 1'b1);
      if (done) begin
        n_done++;
        check("done_lag", cyc - last_acc_cyc, 1);
        check("done_sb_empty", exp_q.size(), 0);
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_beat = {filter_pix, ref_pix, ref_valid, out_last};
    end
  end

  task automatic report();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    report();
    $fatal(1, "watchdog");
  end

  // main stimulus
  initial begin
    int t;
    for (int i = 0; i < (1 << AW); i++) begin
      filt_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i]  = {$urandom, $urandom};
    end
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    filt_base = '0;
    ref_base = '0;
    filt_data = '0;
    ref_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd", {filt_rd, ref_rd}, 2'b00);
    check("rst_valid", {out_valid, ref_valid, out_last}, 3'b000);
    check("rst_addr", {filt_addr, ref_addr}, '0);
    check("rst_pix", {filter_pix, ref_pix}, '0);
    @(posedge clk); #1;
    reset = 1'b1;

    // basic block, ready held high, latency check
    start_block(10'h100, 10'h040, 1'b1);
    @(negedge clk);
    check("busy_after_start", busy, 1'b1);
    check("lat_cycle1_valid", out_valid, 1'b0);
    @(negedge clk);
    check("lat_cycle2_valid", out_valid, 1'b0);
    @(negedge clk);
    check("lat_first_valid", out_valid, 1'b1);
    wait_done(100);
    check("sb_empty_1", exp_q.size(), 0);
    check("beats_1", n_acc, BEATS);

    // same block under random backpressure
    rnd_ready = 1'b1;
    start_block(10'h100, 10'h040, 1'b1);
    wait_done(400);
    check("beats_2", n_acc, BEATS);
    for (int k = 0; k < 3; k++) begin
      start_block(AW'($urandom), AW'($urandom), 1'b1);
      wait_done(400);
      check("beats_rand", n_acc, BEATS);
    end
    rnd_ready = 1'b0;

    // start during STREAM is ignored
    start_block(10'h200, 10'h300, 1'b1);
    t = 0;
    while (dbg_state != 2'd2 && t < 50) begin
      @(posedge clk);
      t++;
    end
    check("reach_stream", dbg_state, 2'd2);
    #1;
    start = 1'b1;
    filt_base = 10'h3AA;
    ref_base = 10'h155;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    repeat (20) @(posedge clk);
    check("single_done", n_done, exp_done);

    // address wrap
    start_block(10'h3FC, 10'h3FE, 1'b1);
    wait_done(100);
    check("sb_empty_wrap", exp_fa_q.size() + exp_ra_q.size(), 0);

    // reset mid-block, then a fresh block
    start_block(10'h080, 10'h010, 1'b0);
    t = 0;
    while (n_acc < 9 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    reset = 1'b0;
    flush_sb();
    @(negedge clk);
    check("midrst_valid", {out_valid, busy, done, filt_rd, ref_rd}, 5'b0);
    check("midrst_pix", {filter_pix, ref_pix}, '0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    check("no_done_after_reset", n_done, exp_done);
    start_block(10'h0C0, 10'h020, 1'b1);
    wait_done(100);
    check("beats_after_reset", n_acc, BEATS);

`ifdef FRAC_FEED_ABORT_EN
    // abort mid-block, then a fresh block
    start_block(10'h150, 10'h250, 1'b0);
    t = 0;
    while (n_acc < 5 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    flush_sb();
    @(negedge clk);
    check("abort_valid", {out_valid, busy}, 2'b00);
    check("abort_state", dbg_state, 2'd0);
    repeat (20) @(posedge clk);
    check("no_done_after_abort", n_done, exp_done);
    start_block(10'h160, 10'h260, 1'b1);
    wait_done(100);
    check("beats_after_abort", n_acc, BEATS);
`endif

    repeat (5) @(posedge clk);
    check("done_count", n_done, exp_done);
    check("sb_final_empty", exp_q.size(), 0);
    report();
    $finish;
  end

endmodule
